// File: rtl/ex_mdu_pkg.sv
// Shared types for the EX-stage multiply/divide unit: op encodings and FSM states.
// Imported by ex_mdu and by anything that drives its mdu_op port.
package ex_mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_MFHI  = 3'd6,
    MDU_MFLO  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/ex_mdu_div_radix2.sv
// Iterative radix-2 restoring divider for ex_mdu; one quotient bit per cycle, sign fix-up on exit.
// Only built when MDU_DIV_EN is defined.
`ifdef MDU_DIV_EN
module ex_mdu_div_radix2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         is_signed,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W);

  logic          running;
  logic [CW-1:0] cnt;
  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  dvs;
  logic [W-1:0]  dvd_raw;
  logic          neg_q;
  logic          neg_r;
  logic          by_zero;

  logic [W:0]    partial;
  logic [W:0]    diff;
  logic          q_bit;
  logic [W-1:0]  rem_n;
  logic [W-1:0]  quo_n;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic sgn);
    return (sgn && x[W-1]) ? -x : x;
  endfunction

  // Shift the next dividend bit into the remainder and keep the difference if it did not borrow.
  always_comb begin
    partial = {rem, quo[W-1]};
    diff    = partial - {1'b0, dvs};
    q_bit   = ~diff[W];
    rem_n   = q_bit ? diff[W-1:0] : partial[W-1:0];
    quo_n   = {quo[W-2:0], q_bit};
  end

  assign done      = running && (cnt == CW'(W - 1));
  assign quotient  = by_zero ? '1      : (neg_q ? -quo_n : quo_n);
  assign remainder = by_zero ? dvd_raw : (neg_r ? -rem_n : rem_n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      running <= 1'b0;
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      dvd_raw <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      by_zero <= 1'b0;
    end else if (abort) begin
      running <= 1'b0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      rem     <= '0;
      quo     <= mag(dividend, is_signed);
      dvs     <= mag(divisor, is_signed);
      dvd_raw <= dividend;
      neg_q   <= is_signed && (dividend[W-1] ^ divisor[W-1]);
      neg_r   <= is_signed && dividend[W-1];
      by_zero <= (divisor == '0);
    end else if (running) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt + CW'(1);
      if (done) running <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle multiply/divide unit with architectural HI/LO beside the EX-stage ALU.
// Define MDU_DIV_EN to build the divider; without it DIV/DIVU retire as no-ops.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              op_valid,
  input  mdu_op_e           mdu_op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              stallreq,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output mdu_state_e        dbg_state
);

  // Handshake: op_valid is the EX instruction's valid; stallreq is the inverse of ready.
  // An op is consumed on an edge where op_valid=1 and stallreq=0; flush kills it instead.

  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  mdu_state_e            state;
  mdu_state_e            state_n;
  logic [CNT_W-1:0]      mul_cnt;
  logic [DATA_W-1:0]     mul_a;
  logic [DATA_W-1:0]     mul_b;
  logic                  mul_signed;
  logic [2*DATA_W-1:0]   mul_ext_a;
  logic [2*DATA_W-1:0]   mul_ext_b;
  logic [2*DATA_W-1:0]   product;

  logic accept;
  logic launch_mul;
  logic mul_last;
  logic wr_hi;
  logic wr_lo;

  assign accept     = (state == ST_IDLE) && op_valid && !flush;
  assign launch_mul = accept && ((mdu_op == MDU_MULT) || (mdu_op == MDU_MULTU));
  assign wr_hi      = accept && (mdu_op == MDU_MTHI);
  assign wr_lo      = accept && (mdu_op == MDU_MTLO);
  assign mul_last   = (mul_cnt == CNT_W'(MUL_LAT - 1));

  // Extending to 2*DATA_W lets one unsigned multiply serve both signednesses modulo 2^(2*DATA_W).
  assign mul_ext_a = mul_signed ? {{DATA_W{mul_a[DATA_W-1]}}, mul_a} : {{DATA_W{1'b0}}, mul_a};
  assign mul_ext_b = mul_signed ? {{DATA_W{mul_b[DATA_W-1]}}, mul_b} : {{DATA_W{1'b0}}, mul_b};
  assign product   = mul_ext_a * mul_ext_b;

`ifdef MDU_DIV_EN
  logic              launch_div;
  logic              div_abort;
  logic              div_done;
  logic [DATA_W-1:0] div_q;
  logic [DATA_W-1:0] div_r;

  assign launch_div = accept && ((mdu_op == MDU_DIV) || (mdu_op == MDU_DIVU));
  assign div_abort  = (state == ST_DIV) && flush;

  ex_mdu_div_radix2 #(
    .W(DATA_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (launch_div),
    .abort     (div_abort),
    .is_signed (mdu_op == MDU_DIV),
    .dividend  (src1),
    .divisor   (src2),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );
`endif

  always_comb begin
    state_n  = state;
    stallreq = 1'b0;
    case (state)
      ST_IDLE: begin
        if (launch_mul) begin
          state_n  = ST_MUL;
          stallreq = 1'b1;
        end
`ifdef MDU_DIV_EN
        else if (launch_div) begin
          state_n  = ST_DIV;
          stallreq = 1'b1;
        end
`endif
      end
      ST_MUL: begin
        if (flush) begin
          state_n = ST_IDLE;
        end else begin
          stallreq = 1'b1;
          if (mul_last) state_n = ST_DONE;
        end
      end
`ifdef MDU_DIV_EN
      ST_DIV: begin
        if (flush) begin
          state_n = ST_IDLE;
        end else begin
          stallreq = 1'b1;
          if (div_done) state_n = ST_DONE;
        end
      end
`endif
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    case (mdu_op)
      MDU_MFHI: rdata = hi;
      MDU_MFLO: rdata = lo;
      default:  rdata = '0;
    endcase
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      mul_cnt    <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_MUL && !flush) mul_cnt <= mul_cnt + CNT_W'(1);
      else                           mul_cnt <= '0;
      if (launch_mul) begin
        mul_a      <= src1;
        mul_b      <= src2;
        mul_signed <= (mdu_op == MDU_MULT);
      end
    end
  end

  // HI/LO take results only on the edge entering DONE; a flush leaves them untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == ST_MUL && !flush && mul_last) begin
      hi <= product[2*DATA_W-1:DATA_W];
      lo <= product[DATA_W-1:0];
    end
`ifdef MDU_DIV_EN
    else if (state == ST_DIV && !flush && div_done) begin
      hi <= div_r;
      lo <= div_q;
    end
`endif
    else begin
      if (wr_hi) hi <= src1;
      if (wr_lo) lo <= src1;
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: driver pushes model results, a negedge monitor checks each retirement.
// Follows MDU_DIV_EN so the reference model matches the build being simulated.
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  localparam int W       = 32;
  localparam int MUL_LAT = 2;
  localparam int EW      = 8 + 3 * W;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk      = 1'b0;
  logic         rst      = 1'b0;
  logic         flush    = 1'b0;
  logic         op_valid = 1'b0;
  mdu_op_e      mdu_op   = MDU_MFHI;
  logic [W-1:0] src1     = '0;
  logic [W-1:0] src2     = '0;
  logic         stallreq;
  logic [W-1:0] rdata;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  mdu_state_e   dbg_state;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  hi_m = '0;
  logic [W-1:0]  lo_m = '0;
  bit            sb_en = 1'b0;

  ex_mdu #(
    .DATA_W  (W),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .op_valid  (op_valid),
    .mdu_op    (mdu_op),
    .src1      (src1),
    .src2      (src2),
    .stallreq  (stallreq),
    .rdata     (rdata),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural result of one op, plus how many cycles it should stall.
  task automatic model_op(input mdu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int fc, output logic [EW-1:0] e);
    int             stalls;
    int             ia;
    int             ib;
    longint         sp;
    longint unsigned up;
    logic [W-1:0]   nh;
    logic [W-1:0]   nl;
    logic [W-1:0]   rd;
    bit             killed;
    nh = hi_m; nl = lo_m; rd = '0; stalls = 0;
    ia = a; ib = b;
    case (op)
      MDU_MULT: begin
        stalls = 1 + MUL_LAT;
        sp = longint'(ia) * longint'(ib);
        nh = sp[63:32]; nl = sp[31:0];
      end
      MDU_MULTU: begin
        stalls = 1 + MUL_LAT;
        up = longint'(a) * longint'(b);
        nh = up[63:32]; nl = up[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        if (DIV_EN) begin
          stalls = 1 + W;
          if (b == 0) begin
            nl = '1; nh = a;
          end else if (op == MDU_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            nl = a; nh = '0;
          end else if (op == MDU_DIV) begin
            nl = ia / ib; nh = ia % ib;
          end else begin
            nl = a / b; nh = a % b;
          end
        end
      end
      MDU_MTHI: nh = a;
      MDU_MTLO: nl = a;
      MDU_MFHI: rd = hi_m;
      MDU_MFLO: rd = lo_m;
      default: ;
    endcase
    killed = (fc >= 0) && ((fc < stalls) || (fc == 0));
    if (killed) begin
      stalls = fc; nh = hi_m; nl = lo_m;
    end
    hi_m = nh; lo_m = nl;
    e = {8'(stalls), rd, nh, nl};
  endtask

  // driver: hold the op in EX until it retires (stallreq low) or the cycle flush is applied
  task automatic issue(input mdu_op_e op, input logic [W-1:0] a, input logic [W-1:0] b, input int fc);
    logic [EW-1:0] e;
    int cyc;
    model_op(op, a, b, fc, e);
    exp_q.push_back(e);
    op_valid = 1'b1; mdu_op = op; src1 = a; src2 = b; cyc = 0;
    forever begin
      flush = (cyc == fc);
      @(negedge clk);
      if (!stallreq || flush) break;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 200) begin
        total++; bad++;
        $display("FAIL issue_timeout: op %0d still stalled after %0d cycles", op, cyc);
        break;
      end
    end
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); #1;
    end
  endtask

  // monitor / scoreboard
  logic [EW-1:0] cur;
  bit            post = 1'b0;
  int            stall_cnt = 0;

  always @(negedge clk) begin
    if (sb_en) begin
      if (post) begin
        chk("hi", hi, cur[2*W-1:W]);
        chk("lo", lo, cur[W-1:0]);
        chk("busy_after", busy, 1'b0);
        post = 1'b0;
      end
      if (op_valid) begin
        if (stallreq && !flush) begin
          stall_cnt++;
        end else if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_underflow: retirement with empty queue at %0t", $time);
        end else begin
          cur = exp_q.pop_front();
          chk("rdata", rdata, cur[3*W-1:2*W]);
          chk("stalls", stall_cnt, cur[EW-1:3*W]);
          stall_cnt = 0;
          post = 1'b1;
        end
      end
    end
  end

  initial begin
    mdu_op_e      op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           ns;
    int           fc;
    int           guard;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, '0);
    chk("rst_lo", lo, '0);
    chk("rst_rdata", rdata, '0);
    chk("rst_stallreq", stallreq, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_state", dbg_state, ST_IDLE);
    rst = 1'b1;
    @(posedge clk); #1;
    sb_en = 1'b1;

    issue(MDU_MULT,  32'hFFFF_FFFE, 32'd3, -1);
    issue(MDU_MFHI,  '0, '0, -1);
    issue(MDU_MFLO,  '0, '0, -1);
    issue(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, -1);
    issue(MDU_DIV,   32'hFFFF_FFF9, 32'd2, -1);
    issue(MDU_DIVU,  32'd100, 32'd7, -1);
    issue(MDU_DIVU,  32'h1234, 32'd0, -1);
    issue(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, -1);
    issue(MDU_MTHI,  32'hA5A5_A5A5, '0, -1);
    issue(MDU_MFHI,  '0, '0, -1);
    issue(MDU_MTLO,  32'hA5A5_A5A5, '0, 0);
    issue(MDU_MFLO,  '0, '0, -1);
    issue(MDU_MULT,  32'd5, 32'd6, -1);
    issue(MDU_DIV,   32'd1000, 32'd3, 10);
    issue(MDU_MFLO,  '0, '0, -1);
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

    for (int i = 0; i < 40; i++) begin
      op = mdu_op_e'(3'($urandom_range(0, 7)));
      a  = $urandom();
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = '1;
        2:       b = W'($urandom_range(1, 20));
        default: b = $urandom();
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if (op == MDU_MULT || op == MDU_MULTU)     ns = 1 + MUL_LAT;
      else if (op == MDU_DIV || op == MDU_DIVU) ns = DIV_EN ? 1 + W : 0;
      else                                      ns = 0;
      fc = -1;
      if ($urandom_range(0, 5) == 0) fc = (ns == 0) ? 0 : $urandom_range(0, ns - 1);
      issue(op, a, b, fc);
    end

    issue(MDU_MTHI, 32'h0000_0001, '0, -1);
    issue(MDU_MTLO, 32'h0000_0002, '0, -1);

    guard = 0;
    while ((exp_q.size() != 0 || post) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    total++;
    if (exp_q.size() != 0 || post) begin
      bad++;
      $display("FAIL drain: %0d entries left in queue", exp_q.size());
    end
    sb_en = 1'b0;

    // asynchronous reset in the middle of a multiply
    op_valid = 1'b1; mdu_op = MDU_MULT; src1 = 32'd5; src2 = 32'd7;
    @(posedge clk); #1;
    mdu_op = MDU_MFHI;
    chk("mid_mul_busy", busy, 1'b1);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_hi", hi, '0);
    chk("arst_lo", lo, '0);
    chk("arst_rdata", rdata, '0);
    chk("arst_stallreq", stallreq, 1'b0);
    chk("arst_busy", busy, 1'b0);
    op_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
